// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: fetch stage of tinker_core. It owns the fetch PC, issues one word read at a time,
// and buffers returned words for decode. Optional perf counters are enabled with `define TINKER_FETCH_PERF_EN.
module tinker_fetch_unit #(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(64'h2000),
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  output logic [PC_W-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            hlt_in,
  output logic            instr_valid,
  output logic [31:0]     instr_word,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            hlt,
  output logic            fetch_err
`ifdef TINKER_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [PC_W-1:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic [PC_W-1:0]  r_req_pc, w_req_pc_nxt;
  logic             r_drop, w_drop_nxt;
  logic             r_mem_req_valid;
  logic [31:0]      r_buf_word [BUF_DEPTH];
  logic [PC_W-1:0]  r_buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_active, w_fire_req, w_pop, w_push, w_flush;

  assign w_active   = (r_state == S_RUN) || (r_state == S_WAIT);
  assign w_fire_req = r_mem_req_valid & mem_req_ready;
  assign w_pop      = instr_valid & instr_ready;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_fetch_pc;
  assign instr_valid   = (r_count != CNT_W'(0));
  assign instr_word    = r_buf_word[r_rd_ptr];
  assign instr_pc      = r_buf_pc[r_rd_ptr];
  assign hlt           = (r_state == S_HALT);
  assign fetch_err     = (r_state == S_ERR);

  // Control: halt beats misaligned redirect beats redirect beats normal fetch; HALT/ERR are terminal.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    if (!w_active) begin
      w_state_nxt = r_state;
    end else if (hlt_in) begin
      w_state_nxt = S_HALT;
      w_flush     = 1'b1;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      w_state_nxt = S_ERR;
      w_flush     = 1'b1;
    end else if (redirect_valid) begin
      w_flush        = 1'b1;
      w_fetch_pc_nxt = redirect_pc;
      if (r_state == S_WAIT) begin
        // a response landing now is stale; otherwise the next one must be dropped
        if (mem_rsp_valid) begin
          w_state_nxt = S_RUN;
          w_drop_nxt  = 1'b0;
        end else begin
          w_drop_nxt  = 1'b1;
        end
      end else if (w_fire_req) begin
        w_state_nxt  = S_WAIT;
        w_req_pc_nxt = r_fetch_pc;
        w_drop_nxt   = 1'b1;
      end else begin
        w_drop_nxt   = 1'b0;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_fire_req) begin
            w_state_nxt    = S_WAIT;
            w_req_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + PC_W'(3'd4);
            w_drop_nxt     = 1'b0;
          end else begin
            w_state_nxt    = S_RUN;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            w_push      = ~r_drop;
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Next buffer occupancy.
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = CNT_W'(0);
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // State, PCs and instruction buffer; request valid is precomputed from next state so it is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_RUN;
      r_fetch_pc      <= RESET_PC;
      r_req_pc        <= PC_W'(0);
      r_drop          <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_rd_ptr        <= PTR_W'(0);
      r_wr_ptr        <= PTR_W'(0);
      r_count         <= CNT_W'(0);
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_word[i] <= 32'd0;
        r_buf_pc[i]   <= PC_W'(0);
      end
    end else begin
      r_state         <= w_state_nxt;
      r_fetch_pc      <= w_fetch_pc_nxt;
      r_req_pc        <= w_req_pc_nxt;
      r_drop          <= w_drop_nxt;
      r_count         <= w_count_nxt;
      r_mem_req_valid <= (w_state_nxt == S_RUN) && (w_count_nxt < DEPTH_C);
      if (w_flush) begin
        r_rd_ptr <= PTR_W'(0);
        r_wr_ptr <= PTR_W'(0);
      end else begin
        if (w_push) begin
          r_buf_word[r_wr_ptr] <= mem_rsp_data;
          r_buf_pc[r_wr_ptr]   <= r_req_pc;
          r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

`ifdef TINKER_FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;
  logic        w_stall;

  assign w_stall      = (r_state == S_RUN) && (r_count == DEPTH_C);
  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Self-checking bench for tinker_fetch_unit: cycle table after reset, directed corner sequences,
// and randomized traffic checked against an in-order PC-stream model with a behavioural memory.
module tb_tinker_fetch_unit;
  localparam int PC_W  = 64;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid;
  logic [PC_W-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            hlt_in;
  logic            instr_valid;
  logic [31:0]     instr_word;
  logic [PC_W-1:0] instr_pc;
  logic            instr_ready;
  logic            hlt;
  logic            fetch_err;
`ifdef TINKER_FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  tinker_fetch_unit #(.PC_W(PC_W), .RESET_PC(64'h2000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .hlt_in(hlt_in),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .hlt(hlt), .fetch_err(fetch_err)
`ifdef TINKER_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural memory state
  bit          mem_pend;
  logic [63:0] mem_addr;
  int          mem_dly;
  int          cfg_min_dly, cfg_max_dly, cfg_ready_pct;

  typedef struct {
    logic        rdy;
    logic        mrv;
    logic        iv;
    logic [63:0] pc;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F ^ {a[47:32], 16'h0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs at the falling edge: checks request legality, then drives response/ready for the next rising edge.
  task automatic mem_tick();
    if (mem_req_valid) begin
      check("req_align", {62'd0, mem_req_addr[1:0]}, 64'd0);
      check("req_while_outstanding", {63'd0, mem_pend}, 64'd0);
    end
    mem_rsp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_dly == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(mem_addr);
        mem_pend      = 1'b0;
      end else begin
        mem_dly--;
      end
    end
    mem_req_ready = ($urandom_range(99) < cfg_ready_pct);
    if (mem_req_valid && mem_req_ready) begin
      mem_pend = 1'b1;
      mem_addr = mem_req_addr;
      mem_dly  = $urandom_range(cfg_max_dly, cfg_min_dly);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    hlt_in         = 1'b0;
    mem_tick();
  endtask

  task automatic clear_inputs();
    mem_pend       = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    hlt_in         = 1'b0;
    instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_tick();
  endtask

  task automatic wait_pend(input string nm);
    for (int i = 0; i < 20 && !mem_pend; i++) step();
    check(nm, {63'd0, mem_pend}, 64'd1);
  endtask

  task automatic wait_iv(input string nm);
    for (int i = 0; i < 40 && !instr_valid; i++) step();
    check(nm, {63'd0, instr_valid}, 64'd1);
  endtask

  function automatic vec_t mk(input logic rdy, input logic mrv, input logic iv, input logic [63:0] pc);
    vec_t v;
    v.rdy = rdy; v.mrv = mrv; v.iv = iv; v.pc = pc;
    return v;
  endfunction

  initial begin
    logic [63:0] exp_pc, ra, p_pc;
    logic [31:0] p_word;
    logic        redir, rdy_used, p_iv;
    int          pops;

    reset = 1'b0;
    clear_inputs();
    cfg_min_dly = 0; cfg_max_dly = 0; cfg_ready_pct = 100;

    // rdy = instr_ready during the edge that precedes the sample
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 64'h0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 64'h0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 64'h2000);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 64'h0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 64'h2004);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 64'h0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 64'h2008);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 64'h2008);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 64'h2008);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 64'h2008);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 64'h2008);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 64'h2008);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 64'h200C);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 64'h0);
    tbl[15] = mk(1'b1, 1'b1, 1'b1, 64'h2010);

    // reset state
    #12;
    check("rst_mrv",  {63'd0, mem_req_valid}, 64'd0);
    check("rst_addr", mem_req_addr, 64'h2000);
    check("rst_iv",   {63'd0, instr_valid}, 64'd0);
    check("rst_word", {32'd0, instr_word}, 64'd0);
    check("rst_pc",   instr_pc, 64'd0);
    check("rst_hlt",  {63'd0, hlt}, 64'd0);
    check("rst_err",  {63'd0, fetch_err}, 64'd0);

    // cycle table with a zero-wait always-ready memory
    do_reset();
    for (int n = 1; n < 16; n++) begin
      instr_ready = tbl[n].rdy;
      step();
      check($sformatf("tbl%0d_mrv", n), {63'd0, mem_req_valid}, {63'd0, tbl[n].mrv});
      check($sformatf("tbl%0d_iv", n),  {63'd0, instr_valid},   {63'd0, tbl[n].iv});
      check($sformatf("tbl%0d_hlt", n), {62'd0, hlt, fetch_err}, 64'd0);
      if (tbl[n].iv) begin
        check($sformatf("tbl%0d_pc", n),   instr_pc, tbl[n].pc);
        check($sformatf("tbl%0d_word", n), {32'd0, instr_word}, {32'd0, mem_word(tbl[n].pc)});
      end
    end

    // redirect to 0x3000 with a response outstanding and a word buffered
    do_reset();
    cfg_min_dly = 3; cfg_max_dly = 3;
    for (int i = 0; i < 20 && !(instr_valid && mem_pend); i++) step();
    check("redir_setup", {62'd0, instr_valid, mem_pend}, 64'd3);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    step();
    check("redir_flush_iv", {63'd0, instr_valid}, 64'd0);
    instr_ready = 1'b1;
    cfg_min_dly = 0; cfg_max_dly = 0;
    wait_iv("redir_wait_iv");
    check("redir_pc",   instr_pc, 64'h3000);
    check("redir_word", {32'd0, instr_word}, {32'd0, mem_word(64'h3000)});

    // misaligned redirect goes to ERROR
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3002;
    step();
    check("mis_err", {63'd0, fetch_err}, 64'd1);
    check("mis_hlt", {63'd0, hlt}, 64'd0);
    check("mis_iv",  {63'd0, instr_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("mis_no_req", {62'd0, mem_req_valid, instr_valid}, 64'd0);
    end

    // halt in WAIT together with a redirect
    do_reset();
    cfg_min_dly = 2; cfg_max_dly = 2;
    instr_ready = 1'b0;
    wait_pend("hlt_setup");
    step();
    hlt_in         = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    step();
    check("hlt_set", {62'd0, hlt, fetch_err}, 64'd2);
    check("hlt_iv",  {63'd0, instr_valid}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("hlt_quiet", {61'd0, mem_req_valid, instr_valid, hlt}, 64'd1);
    end

    // randomized traffic against the in-order PC stream model
    do_reset();
    cfg_min_dly = 0; cfg_max_dly = 3; cfg_ready_pct = 70;
    exp_pc = 64'h2000;
    pops   = 0;
    for (int c = 0; c < 1500; c++) begin
      redir = ($urandom_range(99) < 3);
      if (redir) begin
        ra = {32'd0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
        if ($urandom_range(9) == 0) ra = 64'hFFFF_FFFF_FFFF_FFF0;
        redirect_valid = 1'b1;
        redirect_pc    = ra;
        instr_ready    = 1'b0;
      end else begin
        instr_ready = ($urandom_range(99) < 70);
      end
      rdy_used = instr_ready;
      p_iv = instr_valid; p_pc = instr_pc; p_word = instr_word;
      if (instr_valid && instr_ready) begin
        check("rnd_pc",   instr_pc, exp_pc);
        check("rnd_word", {32'd0, instr_word}, {32'd0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        pops++;
      end
      if (redir) exp_pc = ra;
      step();
      if (p_iv && !rdy_used && !redir) begin
        check("rnd_hold_iv", {63'd0, instr_valid}, 64'd1);
        check("rnd_hold_pc", instr_pc, p_pc);
        check("rnd_hold_word", {32'd0, instr_word}, {32'd0, p_word});
      end
    end
    check("rnd_progress", {63'd0, (pops > 100)}, 64'd1);

    // asynchronous reset in the middle of WAIT
    cfg_min_dly = 3; cfg_max_dly = 3; cfg_ready_pct = 100;
    instr_ready = 1'b1;
    wait_pend("arst_setup");
    step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_mrv",  {63'd0, mem_req_valid}, 64'd0);
    check("arst_iv",   {63'd0, instr_valid}, 64'd0);
    check("arst_flags", {62'd0, hlt, fetch_err}, 64'd0);
    check("arst_addr", mem_req_addr, 64'h2000);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    cfg_min_dly = 0; cfg_max_dly = 0;
    instr_ready = 1'b0;
    mem_tick();
    wait_iv("arst_wait_iv");
    check("arst_restart_pc", instr_pc, 64'h2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
